// File: rtl/core_mem_arbiter_pkg.sv
// Shared types and defaults for the core-to-memory arbiter.
package core_mem_arbiter_pkg;

    localparam int unsigned ARB_NUM_CORES   = 4;
    localparam int unsigned ARB_OUTSTANDING = 8;
    localparam int unsigned ARB_CNT_WIDTH   = 32;

    typedef logic [$clog2(ARB_NUM_CORES)-1:0] core_id_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } request_t;

    typedef enum logic [0:0] {
        SlotEmpty,
        SlotFull
    } slot_state_e;

endpackage

// File: rtl/core_mem_arbiter_if.sv
// Bundles the per-core request/response signals and the memory-controller port.
interface core_mem_arbiter_if
    import core_mem_arbiter_pkg::*;
#(
    parameter int unsigned NUM_CORES = ARB_NUM_CORES
) ();

    logic [NUM_CORES-1:0] core_req_valid;
    request_t             core_req [NUM_CORES];
    logic [NUM_CORES-1:0] core_req_ready;
    logic [NUM_CORES-1:0] core_rsp_valid;
    request_t             core_rsp;
    logic                 mem_req_valid;
    request_t             mem_req;
    logic                 mem_req_ready;
    logic                 mem_rsp_valid;
    request_t             mem_rsp;

    // Arbiter side.
    modport slave (
        input  core_req_valid, core_req, mem_req_ready, mem_rsp_valid, mem_rsp,
        output core_req_ready, core_rsp_valid, core_rsp, mem_req_valid, mem_req
    );

    // Environment side: cores plus memory controller.
    modport master (
        output core_req_valid, core_req, mem_req_ready, mem_rsp_valid, mem_rsp,
        input  core_req_ready, core_rsp_valid, core_rsp, mem_req_valid, mem_req
    );

endinterface

// File: rtl/arb_id_fifo.sv
// In-order FIFO of granted core ids; the head names the core owed the next response.
module arb_id_fifo #(
    parameter int unsigned Depth = 8,
    parameter int unsigned Width = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] push_data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [Width-1:0] head_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PtrW:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == (PtrW + 1)'(Depth));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rptr_q];

    always_comb begin
        wptr_d = wptr_q + PtrW'(do_push);
        rptr_d = rptr_q + PtrW'(do_pop);
        cnt_d  = cnt_q + (PtrW + 1)'(do_push) - (PtrW + 1)'(do_pop);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only read once counted valid.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/core_mem_arbiter.sv
// Round-robin arbiter sharing one memory-controller port among cores, with in-order response routing.
// Optional per-core grant/stall counters are built when ARB_PERF_CNT_EN is defined.
module core_mem_arbiter
    import core_mem_arbiter_pkg::*;
#(
    parameter int unsigned NUM_CORES   = ARB_NUM_CORES,
    parameter int unsigned OUTSTANDING = ARB_OUTSTANDING
`ifdef ARB_PERF_CNT_EN
    ,
    parameter int unsigned CNT_WIDTH   = ARB_CNT_WIDTH
`endif
) (
    input  logic              clk,
    input  logic              reset,
    core_mem_arbiter_if.slave bus,
    output logic              err_unexp_rsp
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] grant_cnt [NUM_CORES],
    output logic [CNT_WIDTH-1:0] stall_cnt [NUM_CORES]
`endif
);

    localparam int unsigned IdW = $clog2(NUM_CORES);

    slot_state_e          slot_q, slot_d;
    logic [IdW-1:0]       rr_q, rr_d, win, head;
    logic                 found, grant, pop, fifo_full, fifo_empty;
    request_t             mem_req_q, mem_req_d, core_rsp_q, core_rsp_d;
    logic [NUM_CORES-1:0] core_rsp_valid_q, core_rsp_valid_d, ready;
    logic                 err_q, err_d;

    // First valid core at or above the rr pointer; IdW-bit addition gives the wrap.
    always_comb begin
        found = 1'b0;
        win   = rr_q;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            if (!found && bus.core_req_valid[rr_q + IdW'(i)]) begin
                found = 1'b1;
                win   = rr_q + IdW'(i);
            end
        end
    end

    // Full FIFO blocks grants even when a pop happens this cycle; reset forces outputs low.
    assign grant = reset && found && !fifo_full && (slot_q == SlotEmpty || bus.mem_req_ready);
    assign ready = grant ? (NUM_CORES'(1) << win) : '0;
    assign pop   = bus.mem_rsp_valid && !fifo_empty;

    always_comb begin
        slot_d    = slot_q;
        mem_req_d = mem_req_q;
        rr_d      = rr_q;
        unique case (slot_q)
            SlotEmpty: if (grant) slot_d = SlotFull;
            SlotFull:  if (!grant && bus.mem_req_ready) slot_d = SlotEmpty;
        endcase
        if (grant) begin
            mem_req_d = bus.core_req[win];
            rr_d      = win + IdW'(1);
        end
    end

    always_comb begin
        core_rsp_valid_d = '0;
        core_rsp_d       = core_rsp_q;
        err_d            = err_q | (bus.mem_rsp_valid & fifo_empty);
        if (pop) begin
            core_rsp_valid_d = NUM_CORES'(1) << head;
            core_rsp_d       = bus.mem_rsp;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_q           <= SlotEmpty;
            rr_q             <= '0;
            mem_req_q        <= '0;
            core_rsp_q       <= '0;
            core_rsp_valid_q <= '0;
            err_q            <= 1'b0;
        end else begin
            slot_q           <= slot_d;
            rr_q             <= rr_d;
            mem_req_q        <= mem_req_d;
            core_rsp_q       <= core_rsp_d;
            core_rsp_valid_q <= core_rsp_valid_d;
            err_q            <= err_d;
        end
    end

    arb_id_fifo #(
        .Depth (OUTSTANDING),
        .Width (IdW)
    ) u_id_fifo (
        .clk_i       (clk),
        .rst_ni      (reset),
        .push_i      (grant),
        .push_data_i (win),
        .pop_i       (pop),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .head_o      (head)
    );

    assign bus.core_req_ready = ready;
    assign bus.mem_req_valid  = (slot_q == SlotFull);
    assign bus.mem_req        = mem_req_q;
    assign bus.core_rsp_valid = core_rsp_valid_q;
    assign bus.core_rsp       = core_rsp_q;
    assign err_unexp_rsp      = err_q;

`ifdef ARB_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] grant_cnt_q [NUM_CORES];
    logic [CNT_WIDTH-1:0] grant_cnt_d [NUM_CORES];
    logic [CNT_WIDTH-1:0] stall_cnt_q [NUM_CORES];
    logic [CNT_WIDTH-1:0] stall_cnt_d [NUM_CORES];

    always_comb begin
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            grant_cnt_d[i] = grant_cnt_q[i] + CNT_WIDTH'(ready[i]);
            stall_cnt_d[i] = stall_cnt_q[i] + CNT_WIDTH'(bus.core_req_valid[i] & ~ready[i]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_CORES; i++) begin
                grant_cnt_q[i] <= '0;
                stall_cnt_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_CORES; i++) begin
                grant_cnt_q[i] <= grant_cnt_d[i];
                stall_cnt_q[i] <= stall_cnt_d[i];
            end
        end
    end

    assign grant_cnt = grant_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule
